// File: rtl/text_loader_if.sv
// Byte-stream sink and data-memory write port of the text loader.
interface text_loader_if;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned WORD_W = 32;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_address;
   logic [WORD_W-1:0] mem_wdata;

   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, mem_we, mem_address, mem_wdata
   );

   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, mem_we, mem_address, mem_wdata
   );
endinterface

// File: rtl/text_loader.sv
// Packs an incoming byte stream big-endian into 32-bit words and writes them
// to the data memory starting at BASE_ADDR, reporting count, done and overflow.
module text_loader #(
   parameter logic [7:0]  BASE_ADDR = 8'h00,
   parameter int unsigned MAX_BYTES = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   text_loader_if.slave  bus,
   output logic          busy,
   output logic          done,
   output logic [8:0]    byte_count,
   output logic          overflow
);

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned CNT_W   = 9;
   localparam int unsigned LANE_W  = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                last_q, last_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;
   logic                in_ready_q, in_ready_d;
   logic                busy_q, busy_d;
   logic                mem_we_q, mem_we_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         word_q     <= '0;
         lane_q     <= '0;
         addr_q     <= '0;
         count_q    <= '0;
         last_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         mem_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         lane_q     <= lane_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         last_q     <= last_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         mem_we_q   <= mem_we_d;
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      lane_d  = lane_q;
      addr_d  = addr_q;
      count_d = count_q;
      last_d  = last_q;
      done_d  = done_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = COLLECT;
               word_d  = '0;
               lane_d  = '0;
               addr_d  = BASE_ADDR;
               count_d = '0;
               last_d  = 1'b0;
               done_d  = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         COLLECT: begin
            if (bus.in_valid && in_ready_q) begin
               unique case (lane_q)
                  2'd0: word_d[31:24] = bus.in_data;
                  2'd1: word_d[23:16] = bus.in_data;
                  2'd2: word_d[15:8]  = bus.in_data;
                  2'd3: word_d[7:0]   = bus.in_data;
               endcase
               lane_d  = LANE_W'(lane_q + 2'd1);
               count_d = CNT_W'(count_q + 9'd1);
               last_d  = bus.in_last;
               if (lane_q == 2'd3 || bus.in_last) begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            // A final byte wins over a simultaneous capacity hit: no overflow then.
            if (last_q) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (count_q == CNT_W'(MAX_BYTES)) begin
               state_d = DONE;
               done_d  = 1'b1;
               ovf_d   = 1'b1;
            end else begin
               state_d = COLLECT;
               addr_d  = ADDR_W'(addr_q + 8'd4);
               lane_d  = '0;
               word_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, decoded from the state being entered.
      in_ready_d = (state_d == COLLECT);
      busy_d     = (state_d == COLLECT) || (state_d == WRITE);
      mem_we_d   = (state_d == WRITE);
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_wdata   = word_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign byte_count      = count_q;
   assign overflow        = ovf_q;

endmodule

// File: tb/tb_text_loader.sv
// Randomized bench for text_loader: three parameterizations checked against a
// word-packing reference model built from the byte list offered.
module tb_text_loader;

   localparam int unsigned N_DUT = 3;
   localparam int unsigned MAXW  = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N_DUT-1:0] start    = '0;
   logic [N_DUT-1:0] in_valid = '0;
   logic [N_DUT-1:0] in_last  = '0;
   logic [7:0]       in_data [N_DUT] = '{8'h00, 8'h00, 8'h00};
   logic [N_DUT-1:0] in_ready, mem_we, busy, done, overflow;
   logic [8:0]       byte_count  [N_DUT];
   logic [7:0]       mem_address [N_DUT];
   logic [31:0]      mem_wdata   [N_DUT];

   logic [7:0]  wr_addr [N_DUT][MAXW];
   logic [31:0] wr_data [N_DUT][MAXW];
   int          wr_cnt   [N_DUT] = '{0, 0, 0};
   int          rdy_viol [N_DUT] = '{0, 0, 0};

   logic [7:0] stim [64];
   int n_checks = 0;
   int n_errors = 0;

   generate
      for (genvar g = 0; g < N_DUT; g++) begin : g_dut
         localparam logic [7:0]  BASE = (g == 2) ? 8'hF8 : 8'h00;
         localparam int unsigned MAXB = (g == 0) ? 256 : 8;
         text_loader_if u_if ();
         assign u_if.in_valid  = in_valid[g];
         assign u_if.in_data   = in_data[g];
         assign u_if.in_last   = in_last[g];
         assign in_ready[g]    = u_if.in_ready;
         assign mem_we[g]      = u_if.mem_we;
         assign mem_address[g] = u_if.mem_address;
         assign mem_wdata[g]   = u_if.mem_wdata;
         text_loader #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[g]),
            .bus        (u_if),
            .busy       (busy[g]),
            .done       (done[g]),
            .byte_count (byte_count[g]),
            .overflow   (overflow[g])
         );
      end
   endgenerate

   // Memory-side log: the memory captures on the negedge of the write cycle.
   always @(negedge clk) begin
      for (int k = 0; k < N_DUT; k++) begin
         if (mem_we[k]) begin
            if (wr_cnt[k] < MAXW) begin
               wr_addr[k][wr_cnt[k]] <= mem_address[k];
               wr_data[k][wr_cnt[k]] <= mem_wdata[k];
            end
            wr_cnt[k] <= wr_cnt[k] + 1;
            if (in_ready[k]) rdy_viol[k] <= rdy_viol[k] + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] base_of(input int k);
      return (k == 2) ? 8'hF8 : 8'h00;
   endfunction

   function automatic int max_of(input int k);
      return (k == 0) ? 256 : 8;
   endfunction

   task automatic check_idle(input int k, input string nm);
      check({nm, "/in_ready"},   32'(in_ready[k]),   32'd0);
      check({nm, "/busy"},       32'(busy[k]),       32'd0);
      check({nm, "/done"},       32'(done[k]),       32'd0);
      check({nm, "/mem_we"},     32'(mem_we[k]),     32'd0);
      check({nm, "/overflow"},   32'(overflow[k]),   32'd0);
      check({nm, "/byte_count"}, 32'(byte_count[k]), 32'd0);
   endtask

   // Start a load at a negedge; returns at the following negedge.
   task automatic pulse_start(input int k);
      @(negedge clk);
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
   endtask

   // Offer stim[0..n-1] with random gaps; last_idx < 0 means no in_last.
   task automatic do_load(input int k, input int n, input int last_idx, input int gap_pct,
                          input bit poke, input string nm, output int first_wr);
      int  i, cyc, acc_cyc, done_cyc, exp_acc, nw, mx;
      bit  v, rdy, poked, exp_ovf;
      logic [31:0] exp_word;
      logic [7:0]  exp_addr;

      pulse_start(k);
      first_wr = wr_cnt[k];
      check({nm, "/start_rdy"},   32'(in_ready[k]),   32'd1);
      check({nm, "/start_busy"},  32'(busy[k]),       32'd1);
      check({nm, "/start_count"}, 32'(byte_count[k]), 32'd0);
      check({nm, "/start_done"},  32'(done[k]),       32'd0);

      i = 0; cyc = 0; acc_cyc = -100; done_cyc = -1; poked = 1'b0;
      while (cyc < 2000) begin
         if (done[k]) begin
            done_cyc = cyc;
            break;
         end
         v = (i < n) && ($urandom_range(99) >= 32'(gap_pct));
         in_valid[k] = v;
         in_data[k]  = v ? stim[i] : 8'($urandom);
         in_last[k]  = v && (i == last_idx);
         if (poke && !poked && i == 2) begin
            start[k] = 1'b1;
            poked    = 1'b1;
         end
         rdy = in_ready[k];
         @(posedge clk);
         cyc++;
         if (v && rdy) begin
            i++;
            acc_cyc = cyc;
         end
         @(negedge clk);
         start[k] = 1'b0;
      end
      in_valid[k] = 1'b0;
      in_last[k]  = 1'b0;

      mx = max_of(k);
      if (last_idx >= 0 && last_idx < mx) begin
         exp_acc = last_idx + 1;
         exp_ovf = 1'b0;
      end else begin
         exp_acc = mx;
         exp_ovf = 1'b1;
      end
      nw = (exp_acc + 3) / 4;

      check({nm, "/timeout"}, 32'(done_cyc >= 0), 32'd1);
      check({nm, "/done_latency"}, 32'(done_cyc - acc_cyc), 32'd1);
      check({nm, "/accepted"},   32'(i),             32'(exp_acc));
      check({nm, "/byte_count"}, 32'(byte_count[k]), 32'(exp_acc));
      check({nm, "/overflow"},   32'(overflow[k]),   32'(exp_ovf));
      check({nm, "/end_rdy"},    32'(in_ready[k]),   32'd0);
      check({nm, "/end_busy"},   32'(busy[k]),       32'd0);
      check({nm, "/n_writes"},   32'(wr_cnt[k] - first_wr), 32'(nw));
      check({nm, "/rdy_in_write"}, 32'(rdy_viol[k]), 32'd0);
      for (int w = 0; w < nw && first_wr + w < MAXW; w++) begin
         exp_word = '0;
         for (int b = 0; b < 4; b++) begin
            exp_word = {exp_word[23:0], (4 * w + b < exp_acc) ? stim[4 * w + b] : 8'h00};
         end
         exp_addr = 8'((int'(base_of(k)) + 4 * w) % 256);
         check({nm, "/wr_addr"}, 32'(wr_addr[k][first_wr + w]), 32'(exp_addr));
         check({nm, "/wr_data"}, wr_data[k][first_wr + w], exp_word);
      end
   endtask

   initial begin
      int fw, n, li, wc;

      repeat (3) @(negedge clk);
      for (int k = 0; k < N_DUT; k++) check_idle(k, "por");
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < N_DUT; k++) check_idle(k, "post_rst");

      // Abort a load after two bytes with an asynchronous reset mid-cycle.
      pulse_start(0);
      wc = wr_cnt[0];
      in_valid[0] = 1'b1; in_data[0] = 8'hAA;
      @(negedge clk);
      in_data[0] = 8'hBB;
      @(negedge clk);
      in_valid[0] = 1'b0;
      check("abort/count2", 32'(byte_count[0]), 32'd2);
      #2 rst = 1'b1;
      #1 check_idle(0, "async_rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_idle(0, "after_abort");
      check("abort/no_write", 32'(wr_cnt[0] - wc), 32'd0);

      // "HOLA" back-to-back, last on the fourth byte.
      stim[0] = 8'h48; stim[1] = 8'h4F; stim[2] = 8'h4C; stim[3] = 8'h41;
      do_load(0, 4, 3, 0, 1'b0, "hola", fw);
      check("hola/word", wr_data[0][fw], 32'h484F4C41);
      check("hola/done", 32'(done[0]), 32'd1);

      // Six bytes with gaps, restarted from DONE.
      for (int b = 0; b < 6; b++) stim[b] = 8'(b + 1);
      do_load(0, 6, 5, 40, 1'b0, "six", fw);
      check("six/word1", wr_data[0][fw + 1], 32'h05060000);

      // Capacity 8, twelve bytes offered without in_last.
      for (int b = 0; b < 12; b++) stim[b] = 8'($urandom);
      do_load(1, 12, -1, 0, 1'b0, "ovf", fw);

      // Spurious start while busy; base 0xF8 with capacity 8.
      for (int b = 0; b < 12; b++) stim[b] = 8'($urandom);
      do_load(2, 12, -1, 0, 1'b1, "f8", fw);
      check("f8/addr_hi", 32'(wr_addr[2][fw + 1]), 32'h000000FC);

      // Random loads.
      for (int r = 0; r < 8; r++) begin
         n = int'($urandom_range(40, 1));
         for (int b = 0; b < n; b++) stim[b] = 8'($urandom);
         do_load(0, n, n - 1, int'($urandom_range(60)), 1'b0, "rnd0", fw);

         n = int'($urandom_range(20, 1));
         li = (n > 8 && $urandom_range(1) == 1) ? -1 : n - 1;
         for (int b = 0; b < n; b++) stim[b] = 8'($urandom);
         do_load(1, n, li, int'($urandom_range(50)), r[0], "rnd1", fw);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/text_loader.md
# text_loader

Upstream fill stage for the data memory. Accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words. Writes each word into the data memory through its `we`/`address`/`wdata` port, so the text is in place before the processor runs. Signals completion, byte count and overflow to the control logic.

## Interface

Parameters:
- `BASE_ADDR`, default 8'h00: byte address of the first word written. Must be a multiple of 4.
- `MAX_BYTES`, default 256: capacity in bytes.
  - Must be a multiple of 4.
  - BASE_ADDR + MAX_BYTES must be ≤ 256.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: clock. All state updates on the posedge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a load. Honoured only in IDLE or DONE.
- `in_valid`  in  1: a byte is offered on `in_data`.
- `in_data`  in  8: byte being offered.
- `in_last`  in  1: qualifies the offered byte as the final byte of the stream.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `mem_we`  out  1: write enable to the data memory.
- `mem_address`  out  8: byte address of the word being written (word-aligned).
- `mem_wdata`  out  32: packed word; the first-received byte is in [31:24].
- `busy`  out  1: a load is in progress (COLLECT or WRITE).
- `done`  out  1: load finished. Held until the next accepted `start` or reset.
- `byte_count`  out  9: number of bytes accepted in the current or last load.
- `overflow`  out  1: stream exceeded MAX_BYTES. Held with `done`.

## Operation

- States: IDLE, COLLECT, WRITE, DONE. All outputs are decoded from registered state, so they are glitch-free.
- Reset forces IDLE. All outputs are 0, and the word buffer, lane, address and counters are cleared.
- IDLE / DONE:
  - `start` → COLLECT.
  - On entry to COLLECT: lane=0, word=0, address=BASE_ADDR, byte_count=0, done=0, overflow=0.
- COLLECT:
  - `in_ready`=1 and `busy`=1.
  - A byte is accepted when `in_valid & in_ready` at a posedge. The byte is stored in lane `lane` (lane0→[31:24] … lane3→[7:0]), then lane and byte_count increment.
  - If the accepted byte is lane 3, or has `in_last`=1 → WRITE. A set last flag is latched.
- WRITE:
  - Lasts one cycle.
  - `mem_we`=1, `mem_address`=current address, `mem_wdata`=word, with lanes not filled = 0x00.
  - `in_ready`=0.
  - Exit condition, checked in this order:
    1. last flag set → DONE.
    2. byte_count==MAX_BYTES → DONE with overflow=1.
    3. Otherwise → COLLECT, with address += 4 (mod 256), lane=0, word=0.
- `mem_we`=0 and `in_ready`=0 in every state except as stated above.
- DONE: `done`=1, `busy`=0. Received bytes beyond capacity are never accepted.
- `start` while busy is ignored.
- Reset mid-load:
  - Returns to IDLE at once; no further write is issued.
  - Memory words already written are not restored.

## Timing

- Byte acceptance happens at the posedge where `in_valid & in_ready`=1. `in_valid` may drop between bytes, and `in_data` is ignored while it is low.
- The fourth byte (or the `in_last` byte) is accepted at edge N. WRITE then spans N→N+1, with `mem_we` high for exactly that cycle. The data memory captures the word at the negedge inside that cycle; address and data are stable from edge N to edge N+1.
- `in_ready` returns high at edge N+1. Peak throughput is 4 bytes per 5 cycles.
- `done` rises at the edge that leaves WRITE, i.e. one cycle after the final byte is accepted.
- `byte_count` updates at the same edge as each acceptance.
- The `start` pulse takes effect at the next edge, so `in_ready` is high from the following cycle.

## Test plan

- Reset asserted asynchronously mid-cycle → all outputs 0 immediately. After release, state is IDLE with `in_ready`=0.
- `start`, then bytes 0x48,0x4F,0x4C,0x41 with `in_last` on the 4th, offered back-to-back → one write at 0x00 with 0x484F4C41, one `mem_we` cycle, `done`=1, `byte_count`=4.
- 6 bytes 0x01..0x06 with random `in_valid` gaps, `in_last` on 0x06 → two writes: 0x00←0x01020304 and 0x04←0x05060000. `byte_count`=6. `in_ready` is low during each WRITE cycle.
- MAX_BYTES=8 with 12 bytes offered and no `in_last` → writes at 0x00 and 0x04, then `done`=1, `overflow`=1, `in_ready`=0. Bytes 9–12 are never accepted.
- Reset asserted after 2 of 4 bytes accepted → no `mem_we` pulse. After a new `start`, the load restarts at BASE_ADDR with `byte_count`=0.
- `start` pulsed while busy → ignored, current load unaffected. BASE_ADDR=0xF8, MAX_BYTES=8 → writes land at 0xF8 and 0xFC, then `overflow`=1.
